// File: rtl/fifo_out_skid.sv
// Three-entry skid buffer between a one-cycle-latency memory read port and a
// ready/valid downstream stream; reads are only issued when a slot is guaranteed.
module fifo_out_skid #(
    parameter int DATA_W     = 16,
    parameter int SKID_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              rd_en,
    output logic              mem_ren,
    input  logic              mem_valid_out,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              host_ready,
    output logic [15:0]       delivered_cnt,
    output logic              ovf_err
);

    logic [1:0]        count;
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic              inflight;
    logic [DATA_W-1:0] entry [SKID_DEPTH];

    logic [2:0] occupancy;
    logic       full;
    logic       push;
    logic       pop;
    logic       accept;
    logic       overflow;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A read is only requested when the word it returns is sure to find a free slot.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign mem_ren   = reset & rd_en & (occupancy < 3'd3);

    assign full      = (count == 2'd3);
    assign out_valid = (count != 2'd0);
    assign out_data  = entry[rd_ptr];

    assign pop      = clk_en & out_valid & host_ready;
    assign push     = clk_en & mem_valid_out;
    assign accept   = push & (~full | pop);
    assign overflow = push & full & ~pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 2'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            inflight <= 1'b0;
        end else if (clk_en) begin
            inflight <= mem_ren;
            if (accept) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // When full with a simultaneous pop, wr_ptr aliases the slot being read out,
    // which is safe because the popped word leaves on this same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (accept) begin
            entry[wr_ptr] <= mem_data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            delivered_cnt <= 16'd0;
            ovf_err       <= 1'b0;
        end else begin
            if (pop) begin
                delivered_cnt <= delivered_cnt + 16'd1;
            end
            if (overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_out_skid.sv
// Randomized and directed bench for fifo_out_skid against a queue-based model
// of the skid buffer and a one-cycle-latency upstream memory.
module tb_fifo_out_skid;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        rd_en;
    logic        mem_ren;
    logic        mem_valid_out;
    logic [15:0] mem_data_out;
    logic        out_valid;
    logic [15:0] out_data;
    logic        host_ready;
    logic [15:0] delivered_cnt;
    logic        ovf_err;

    fifo_out_skid #(.DATA_W(16), .SKID_DEPTH(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .rd_en         (rd_en),
        .mem_ren       (mem_ren),
        .mem_valid_out (mem_valid_out),
        .mem_data_out  (mem_data_out),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .host_ready    (host_ready),
        .delivered_cnt (delivered_cnt),
        .ovf_err       (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_q  [$];
    logic [15:0] upstream [$];
    logic [15:0] sent     [$];
    logic [15:0] log_q    [$];
    int          pop_cyc  [$];
    int          model_inflight;
    int          model_deliv;
    logic        model_ovf;
    logic        mv;
    logic [15:0] md;
    logic        force_valid;
    logic [15:0] force_data;
    int          cyc;
    int          first_ren;
    int          first_val;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: drive inputs at the falling edge, compare, then advance the model
    // to what the coming rising edge must produce.
    task automatic applyStimulus(input logic ce, input logic re, input logic hr);
        logic exp_ren;
        @(negedge clk);
        clk_en        = ce;
        rd_en         = re;
        host_ready    = hr;
        mem_valid_out = force_valid ? 1'b1 : mv;
        mem_data_out  = force_valid ? force_data : md;
        #1;
        exp_ren = re && ((model_q.size() + model_inflight) < 3);
        checkOutput("mem_ren", 32'(mem_ren), 32'(exp_ren));
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("out_data", 32'(out_data), 32'(model_q[0]));
        end
        checkOutput("delivered_cnt", 32'(delivered_cnt), 32'(model_deliv % 65536));
        checkOutput("ovf_err", 32'(ovf_err), 32'(model_ovf));
        if (first_ren < 0 && mem_ren && ce) first_ren = cyc;
        if (first_val < 0 && out_valid) first_val = cyc;
        if (ce) begin
            if (model_q.size() != 0 && hr) begin
                log_q.push_back(model_q.pop_front());
                pop_cyc.push_back(cyc);
                model_deliv++;
            end
            if (mem_valid_out) begin
                if (model_q.size() < 3) model_q.push_back(mem_data_out);
                else model_ovf = 1'b1;
            end
            model_inflight = exp_ren ? 1 : 0;
            if (mem_ren && upstream.size() != 0) begin
                mv = 1'b1;
                md = upstream.pop_front();
            end else begin
                mv = 1'b0;
            end
        end
        cyc++;
    endtask

    // Asserts reset at the current time, checks the cleared outputs at once, and
    // releases at the next falling edge with clk_en low.
    task automatic applyReset();
        reset         = 1'b0;
        rd_en         = 1'b1;
        clk_en        = 1'b1;
        host_ready    = 1'b0;
        force_valid   = 1'b0;
        mem_valid_out = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_mem_ren", 32'(mem_ren), 32'd0);
        checkOutput("rst_delivered", 32'(delivered_cnt), 32'd0);
        checkOutput("rst_ovf", 32'(ovf_err), 32'd0);
        model_q.delete();
        log_q.delete();
        pop_cyc.delete();
        model_inflight = 0;
        model_deliv    = 0;
        model_ovf      = 1'b0;
        mv             = 1'b0;
        md             = 16'h0;
        cyc            = 0;
        first_ren      = -1;
        first_val      = -1;
        @(posedge clk);
        @(negedge clk);
        reset  = 1'b1;
        clk_en = 1'b0;
        rd_en  = 1'b1;
        #1;
        checkOutput("release_mem_ren", 32'(mem_ren), 32'd1);
    endtask

    initial begin
        logic [1:0] ce_pat [4];
        reset         = 1'b0;
        clk_en        = 1'b0;
        rd_en         = 1'b0;
        host_ready    = 1'b0;
        mem_valid_out = 1'b0;
        mem_data_out  = 16'h0;
        force_valid   = 1'b0;
        force_data    = 16'h0;
        ce_pat[0] = 2'd1; ce_pat[1] = 2'd0; ce_pat[2] = 2'd0; ce_pat[3] = 2'd1;

        // Streaming: 1..8 on consecutive cycles, two edges after the first read.
        applyReset();
        upstream.delete();
        for (int i = 1; i <= 8; i++) upstream.push_back(16'(i));
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("stream_latency", 32'(first_val - first_ren), 32'd2);
        checkOutput("stream_count", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) checkOutput("stream_order", 32'(log_q[i]), 32'(i + 1));
        checkOutput("stream_consecutive", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
        checkOutput("stream_delivered", 32'(delivered_cnt), 32'd8);
        checkOutput("stream_empty_valid", 32'(out_valid), 32'd0);

        // Backpressure, then clock-enable gaps, then an empty upstream.
        applyReset();
        upstream.delete();
        for (int i = 1; i <= 20; i++) upstream.push_back(16'(i));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("bp_mem_ren", 32'(mem_ren), 32'd0);
        checkOutput("bp_out_data", 32'(out_data), 32'h0001);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) checkOutput("bp_order", 32'(log_q[i]), 32'(i + 1));
        checkOutput("bp_ovf", 32'(ovf_err), 32'd0);
        for (int i = 0; i < 16; i++) applyStimulus(ce_pat[i % 4][0], 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ce_total", 32'(log_q.size()), 32'd20);
        for (int i = 0; i < 20; i++) checkOutput("ce_order", 32'(log_q[i]), 32'(i + 1));
        checkOutput("empty_valid", 32'(out_valid), 32'd0);
        checkOutput("empty_ovf", 32'(ovf_err), 32'd0);
        checkOutput("empty_delivered", 32'(delivered_cnt), 32'd20);

        // Forced overflow while holding 0x00A0..0x00A2.
        applyReset();
        upstream.delete();
        for (int i = 0; i < 3; i++) upstream.push_back(16'(16'h00A0 + i));
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        force_valid = 1'b1;
        force_data  = 16'h00FF;
        applyStimulus(1'b1, 1'b0, 1'b0);
        force_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("ovf_drain_count", 32'(log_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) checkOutput("ovf_kept", 32'(log_q[i]), 32'(16'h00A0 + i));
        checkOutput("ovf_sticky", 32'(ovf_err), 32'd1);

        // Reset asserted while two words are buffered.
        applyReset();
        upstream.delete();
        for (int i = 1; i <= 10; i++) upstream.push_back(16'(i));
        for (int i = 0; i < 10 && model_q.size() != 2; i++) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mid_fill", 32'(model_q.size()), 32'd2);
        @(posedge clk);
        #2;
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        applyReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b1);

        // Randomized traffic against the model.
        applyReset();
        upstream.delete();
        sent.delete();
        for (int i = 0; i < 150; i++) begin
            upstream.push_back(16'($urandom));
            sent.push_back(upstream[i]);
        end
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 9),
                          1'($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("rand_count", 32'(log_q.size()), 32'd150);
        for (int i = 0; i < 150; i++) checkOutput("rand_order", 32'(log_q[i]), 32'(sent[i]));
        checkOutput("rand_ovf", 32'(ovf_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
